prog_loader: RTL and testbench

Program loader for the 9-bit 3BC processor. It receives a program as a byte stream over a valid/ready handshake and packs each pair of bytes into one 9-bit instruction word. Each word is written sequentially into instruction memory from address 0. When the halt/Ack sentinel 9'h1FF has been written, the block pulses Start to the processor, then waits for the processor's Ack before accepting a new program.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader.sv | 98 +++++++++
 tb/tb_prog_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the 3BC program loader.
package prog_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    LO    = 3'd0,
    HI    = 3'd1,
    WRITE = 3'd2,
    START = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Halt/Ack sentinel; the control unit reserves the same encoding.
  localparam logic [8:0] kAckInstr = 9'h1FF;

endpackage

// File: rtl/prog_loader.sv
// Program loader: packs byte pairs into 9-bit instructions, writes them
// sequentially from address 0, then hands off to the processor via Start/Ack.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [7:0]   ByteIn,
  input  logic         ByteValid,
  output logic         ByteReady,
  output logic         InstrWrEn,
  output logic [A-1:0] InstrAddr,
  output logic [W-1:0] InstrOut,
  output logic         Start,
  output logic         Done,
  input  logic         Ack,
  output logic         Err
);

  state_e         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [W-1:0]   instr_q, instr_d;
  logic           xfer;

  // Handshake and status outputs are pure state decodes (no extra latency)
  assign ByteReady = (state_q == LO) || (state_q == HI);
  assign InstrWrEn = (state_q == WRITE);
  assign Start     = (state_q == START);
  assign Done      = (state_q == RUN);
  assign Err       = (state_q == ERR);
  assign InstrAddr = addr_q;
  assign InstrOut  = instr_q;
  assign xfer      = ByteValid && ByteReady;

  // Next-state, address and instruction-packing logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    unique case (state_q)
      LO: begin
        if (xfer) begin
          instr_d[7:0] = ByteIn;
          state_d      = HI;
        end
      end
      HI: begin
        if (xfer) begin
          // Only bit 0 of the high byte is meaningful; anything else is corrupt
          if (|ByteIn[7:1]) begin
            state_d = ERR;
          end else begin
            instr_d[8] = ByteIn[0];
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        // Terminator is written first, then we hand off. A full memory with
        // no terminator yet is an error rather than a wrap.
        if (instr_q == kAckInstr) begin
          state_d = START;
        end else if (addr_q == {A{1'b1}}) begin
          state_d = ERR;
        end else begin
          addr_d  = addr_q + A'(1);
          state_d = LO;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (Ack) begin
          addr_d  = '0;
          state_d = LO;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = LO;
    endcase
  end

  // State, address and instruction registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= LO;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (A=10 main DUT, A=2 overflow DUT).
module tb_prog_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        Ack = 1'b0;

  logic        ByteReady, InstrWrEn, Start, Done, Err;
  logic [9:0]  InstrAddr;
  logic [8:0]  InstrOut;

  logic        ByteReady2, InstrWrEn2, Start2, Done2, Err2;
  logic [1:0]  InstrAddr2;
  logic [8:0]  InstrOut2;

  int errors = 0;
  int checks = 0;

  logic [9:0] wq_a[$];
  logic [8:0] wq_d[$];
  int         start_cnt = 0;
  logic [1:0] w2_a[$];
  logic [8:0] w2_d[$];
  int         start2_cnt = 0;

  prog_loader #(.A(10), .W(9)) dut (
    .Clk(Clk), .Reset(Reset), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .InstrWrEn(InstrWrEn), .InstrAddr(InstrAddr),
    .InstrOut(InstrOut), .Start(Start), .Done(Done), .Ack(Ack), .Err(Err)
  );

  prog_loader #(.A(2), .W(9)) dut2 (
    .Clk(Clk), .Reset(Reset), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady2), .InstrWrEn(InstrWrEn2), .InstrAddr(InstrAddr2),
    .InstrOut(InstrOut2), .Start(Start2), .Done(Done2), .Ack(Ack), .Err(Err2)
  );

  always #5 Clk = ~Clk;

  // Write/Start monitors, sampled mid-cycle
  always @(negedge Clk) begin
    if (InstrWrEn) begin wq_a.push_back(InstrAddr); wq_d.push_back(InstrOut); end
    if (Start) start_cnt++;
    if (InstrWrEn2) begin w2_a.push_back(InstrAddr2); w2_d.push_back(InstrOut2); end
    if (Start2) start2_cnt++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    wq_a.delete(); wq_d.delete(); w2_a.delete(); w2_d.delete();
    start_cnt = 0; start2_cnt = 0;
  endtask

  task automatic apply_reset();
    Reset = 1'b0; ByteValid = 1'b0; Ack = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    clear_logs();
  endtask

  // Present one byte until the loader takes it (bounded wait)
  task automatic xfer(input logic [7:0] b);
    int n = 0;
    ByteIn = b; ByteValid = 1'b1;
    while (!ByteReady && n < 20) begin tick(); n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL xfer timeout: byte %h never accepted", b);
    end
    tick();
    ByteValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick(); tick();
    checks++;
    if ({ByteReady, InstrWrEn, Start, Done, Err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset ctl: got %b want %b", {ByteReady, InstrWrEn, Start, Done, Err}, 5'b10000);
    end
    checks++;
    if ({InstrAddr, InstrOut} !== 19'd0) begin
      errors++;
      $display("FAIL reset regs: got addr %h out %h want 0 0", InstrAddr, InstrOut);
    end
    Reset = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_basic();
    logic [7:0] tin [12] = '{8'h12, 8'h00, 8'h34, 8'h34, 8'h01, 8'hFF,
                             8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    // {ByteReady, InstrWrEn, Start, Done}
    logic [3:0] ev [12] = '{4'b1000, 4'b1000, 4'b0100, 4'b1000, 4'b1000, 4'b0100,
                            4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
    logic [9:0] wa [3] = '{10'd0, 10'd1, 10'd2};
    logic [8:0] wd [3] = '{9'h012, 9'h134, 9'h1FF};
    int k = 0;
    for (int c = 0; c < 12; c++) begin
      ByteIn = tin[c]; ByteValid = 1'b1;
      checks++;
      if ({ByteReady, InstrWrEn, Start, Done} !== ev[c]) begin
        errors++;
        $display("FAIL basic ctl cyc%0d: got %b want %b", c, {ByteReady, InstrWrEn, Start, Done}, ev[c]);
      end
      if (ev[c][2]) begin
        checks++;
        if (InstrAddr !== wa[k] || InstrOut !== wd[k]) begin
          errors++;
          $display("FAIL basic write cyc%0d: got %h@%0d want %h@%0d", c, InstrOut, InstrAddr, wd[k], wa[k]);
        end
        k++;
      end
      tick();
    end
    ByteValid = 1'b0;
    checks++;
    if (start_cnt !== 1) begin
      errors++;
      $display("FAIL basic start count: got %0d want 1", start_cnt);
    end
  endtask

  task automatic test_ack();
    logic [9:0] ea [2] = '{10'd0, 10'd1};
    logic [8:0] ed [2] = '{9'h055, 9'h1FF};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({Done, ByteReady} !== 2'b10) begin
        errors++;
        $display("FAIL ack hold cyc%0d: got done/ready %b want 10", i, {Done, ByteReady});
      end
      tick();
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    checks++;
    if ({ByteReady, Done, InstrAddr} !== {2'b10, 10'd0}) begin
      errors++;
      $display("FAIL ack return: got ready %b done %b addr %0d want 1 0 0", ByteReady, Done, InstrAddr);
    end
    clear_logs();
    xfer(8'h55);
    Ack = 1'b1;     // ignored while loading
    tick();
    Ack = 1'b0;
    xfer(8'h00); xfer(8'hFF); xfer(8'h01);
    tick(); tick();
    checks++;
    if (wq_a.size() !== 2) begin
      errors++;
      $display("FAIL ack reload count: got %0d want 2", wq_a.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
          errors++;
          $display("FAIL ack reload w%0d: got %h@%0d want %h@%0d", i, wq_d[i], wq_a[i], ed[i], ea[i]);
        end
      end
    end
    checks++;
    if ({Done, start_cnt} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL ack reload run: got done %b starts %0d want 1 1", Done, start_cnt);
    end
  endtask

  task automatic test_gap();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      ByteValid = (c == 0 || c == 5);
      ByteIn    = (c == 0) ? 8'h12 : 8'h00;
      checks++;
      if ({ByteReady, InstrWrEn} !== ((c == 6) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL gap ctl cyc%0d: got %b want %b", c, {ByteReady, InstrWrEn}, (c == 6) ? 2'b01 : 2'b10);
      end
      if (c == 6) begin
        checks++;
        if (InstrAddr !== 10'd0 || InstrOut !== 9'h012) begin
          errors++;
          $display("FAIL gap write: got %h@%0d want 012@0", InstrOut, InstrAddr);
        end
      end
      tick();
    end
    ByteValid = 1'b0;
  endtask

  task automatic test_err();
    apply_reset();
    xfer(8'h12);
    xfer(8'h02);
    checks++;
    if ({Err, ByteReady, InstrWrEn} !== 3'b100) begin
      errors++;
      $display("FAIL err entry: got err/ready/wren %b want 100", {Err, ByteReady, InstrWrEn});
    end
    ByteIn = 8'h01; ByteValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({Err, ByteReady} !== 2'b10) begin
        errors++;
        $display("FAIL err sticky cyc%0d: got %b want 10", i, {Err, ByteReady});
      end
    end
    ByteValid = 1'b0;
    checks++;
    if (wq_a.size() !== 0 || start_cnt !== 0) begin
      errors++;
      $display("FAIL err no-write: got writes %0d starts %0d want 0 0", wq_a.size(), start_cnt);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({Err, ByteReady} !== 2'b01) begin
      errors++;
      $display("FAIL err reset: got err/ready %b want 01", {Err, ByteReady});
    end
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      xfer(8'(i));
      xfer(8'h00);
    end
    tick(); tick();
    checks++;
    if (w2_a.size() !== 4) begin
      errors++;
      $display("FAIL ovf count: got %0d want 4", w2_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (w2_a[i] !== 2'(i) || w2_d[i] !== 9'(i + 1)) begin
          errors++;
          $display("FAIL ovf w%0d: got %h@%0d want %h@%0d", i, w2_d[i], w2_a[i], 9'(i + 1), i);
        end
      end
    end
    checks++;
    if ({Err2, ByteReady2, start2_cnt} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL ovf err: got err %b ready %b starts %0d want 1 0 0", Err2, ByteReady2, start2_cnt);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    xfer(8'h10); xfer(8'h00); xfer(8'h20); xfer(8'h00);
    xfer(8'h77);
    checks++;
    if (wq_a.size() !== 2) begin
      errors++;
      $display("FAIL mid pre-writes: got %0d want 2", wq_a.size());
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({ByteReady, InstrWrEn, Start, Done, Err, InstrAddr, InstrOut} !== {5'b10000, 19'd0}) begin
      errors++;
      $display("FAIL mid reset: got ctl %b addr %0d out %h want 10000 0 0",
               {ByteReady, InstrWrEn, Start, Done, Err}, InstrAddr, InstrOut);
    end
    tick();
    Reset = 1'b1;
    tick();
    clear_logs();
    xfer(8'hAA); xfer(8'h01); xfer(8'hFF); xfer(8'h01);
    tick(); tick();
    checks++;
    if (wq_a.size() !== 2 || start_cnt !== 1) begin
      errors++;
      $display("FAIL mid reload: got writes %0d starts %0d want 2 1", wq_a.size(), start_cnt);
    end else begin
      checks++;
      if ({wq_a[0], wq_d[0], wq_a[1], wq_d[1]} !== {10'd0, 9'h1AA, 10'd1, 9'h1FF}) begin
        errors++;
        $display("FAIL mid reload data: got %h@%0d %h@%0d want 1aa@0 1ff@1",
                 wq_d[0], wq_a[0], wq_d[1], wq_a[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack();
    test_gap();
    test_err();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
